sensor_packet_spi_master: RTL
=============================

Name: sensor_packet_spi_master

Overview:
- SPI Mode 0 master transmitter for the 16-byte sensor packet format consumed by arduino_spi_slave_simple.
- Latches roll/pitch/yaw/gyro/flag inputs on a start request, serialises them MSB-first on sdo, and generates sck and cs_n.
- Sits in the FPGA fabric as the packet source for a downstream SPI slave (MCU or loopback receiver).

Parameters:
- CLK_DIV, 4: sck half-period in clk cycles; must be ≥1.
- CS_SETUP, 2: clk cycles from cs_n falling to the first sck rising edge low phase; must be ≥1.
- CS_HOLD, 2: clk cycles from the last sck falling edge to cs_n rising; must be ≥1.
- CS_GAP, 8: minimum clk cycles cs_n stays high before done/idle; must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one packet; sampled only in IDLE
- roll  in  16  signed angle, packet bytes 1-2
- pitch  in  16  signed angle, packet bytes 3-4
- yaw  in  16  signed angle, packet bytes 5-6
- gyro_x  in  16  signed rate, packet bytes 7-8
- gyro_y  in  16  signed rate, packet bytes 9-10
- gyro_z  in  16  signed rate, packet bytes 11-12
- quat_valid  in  1  flags bit0
- gyro_valid  in  1  flags bit1
- cs_n  out  1  chip select, active low
- sck  out  1  SPI clock, CPOL=0
- sdo  out  1  MOSI data
- busy  out  1  high from the cycle after start is accepted until return to IDLE
- done  out  1  one-cycle pulse on return to IDLE after a completed frame

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (immediate, async) drives: cs_n=1, sck=0, sdo=0, busy=0, done=0, state=IDLE, counters=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Frame layout (128 bits, MSB-first, bytes MSB-then-LSB):
  - byte 0: 0xAA
  - bytes 1-12: roll, pitch, yaw, gyro_x, gyro_y, gyro_z
  - byte 13: {6'b0, gyro_valid, quat_valid}
  - bytes 14-15: 0x00
- The frame is latched into a 128-bit shift register in the cycle start is sampled. Input changes afterwards are ignored until the next accept.

State machine: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - start=1 at cycle T: latch frame.
  - At T+1: cs_n=0, sck=0, sdo=frame[127], busy=1, enter SETUP.
- SETUP:
  - Lasts CS_SETUP cycles.
  - Then SHIFT with bit index 0.
- SHIFT:
  - Each bit is CLK_DIV cycles sck=0 followed by CLK_DIV cycles sck=1.
  - The receiver samples on the rising edge.
  - sdo updates to the next bit in the same cycle sck returns to 0; it never changes while sck=1.
  - Exactly 128 rising edges per frame.
  - After the high phase of bit 127: sck=0, sdo=0, enter HOLD.
- HOLD:
  - CS_HOLD cycles with cs_n=0, sck=0.
  - Then cs_n=1, enter GAP.
- GAP:
  - CS_GAP cycles with cs_n=1.
  - Next cycle: busy=0, done=1 for one cycle, state=IDLE.
- Timing with defaults: start at T gives cs_n low from T+1 to T+1028 inclusive (2+1024+2), and done at T+1037.
- Frame length in general = CS_SETUP + 256·CLK_DIV + CS_HOLD + CS_GAP cycles of busy.

Boundary conditions:
- start while busy: ignored, not queued.
- start high in the same cycle done=1: accepted (state is IDLE). Continuous start therefore yields back-to-back frames separated by ≥CS_GAP cycles of cs_n high.
- rst_n low mid-frame: immediate abort to the reset values; done is not pulsed. The partial frame is discarded by the receiver because its bit counter resets on cs_n high.
- CLK_DIV=1: sck = clk/2; the rules above still hold.
- Counter widths are sized by $clog2 of the parameters. The bit counter is 7 bits and does not wrap inside a frame.

Decomposition:
- Package sensor_spi_pkg holds:
  - HEADER_BYTE=8'hAA, PACKET_BYTES=16, PACKET_BITS=128
  - FLAG_QUAT_VALID=0, FLAG_GYRO_VALID=1
  - state enum type
  - function build_packet(roll..gyro_valid) returning logic [127:0]
- The existing receiver is to be migrated to this package.
- One sub-module, spi_sck_phase_gen:
  - Counts CLK_DIV per half-period.
  - Outputs sck_level, rise_pulse and fall_pulse.
  - Gated by an enable from the FSM.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> cs_n=1, sck=0, sdo=0, busy=0, done=0; no frame begins until rst_n=1.
- Single frame:
  - Stimulus: roll=0x1234, pitch=0xFEDC, yaw=0x0001, gyro_x=0x8000, gyro_y=0x7FFF, gyro_z=0x00FF, quat_valid=1, gyro_valid=0, one-cycle start.
  - Bits sampled at sck rising edges -> AA 12 34 FE DC 00 01 80 00 7F FF 00 FF 01 00 00.
  - Exactly 128 rising edges; sdo stable while sck=1; default timing T+1/T+1028/T+1037.
- Loopback into arduino_spi_slave_simple with the same values -> initialized=1, error=0, quat1_x=0x1234, quat1_y=0xFEDC, gyro1_x=0x8000, quat1_valid=1, gyro1_valid=0.
- Inputs changed to all-zero 10 cycles after start, plus start pulses at bit 20 -> transmitted frame unchanged; exactly one done pulse.
- start held high for 3 frames -> three identical-format frames; cs_n high for exactly CS_GAP+1 cycles between consecutive frames; done pulsed 3 times.
- rst_n asserted at bit 40 high phase -> cs_n=1, sck=0 same timestep; no done; a subsequent start yields a complete correct frame.
- Rerun the single-frame scenario with CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_GAP=1 -> identical byte stream; busy lasts 259 cycles.

Source files
------------

// File: rtl/sensor_spi_pkg.sv
// sensor_spi_pkg: shared constants, FSM state type and
// packet builder for the 16-byte sensor SPI frame.
package sensor_spi_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hAA;
  localparam int PACKET_BYTES = 16;
  localparam int PACKET_BITS = 128;

  localparam int FLAG_QUAT_VALID = 0;
  localparam int FLAG_GYRO_VALID = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  function automatic logic [PACKET_BITS-1:0] build_packet(
    input logic [15:0] roll,
    input logic [15:0] pitch,
    input logic [15:0] yaw,
    input logic [15:0] gyro_x,
    input logic [15:0] gyro_y,
    input logic [15:0] gyro_z,
    input logic        quat_valid,
    input logic        gyro_valid
  );
    logic [7:0] flags;
    flags = 8'h00;
    flags[FLAG_QUAT_VALID] = quat_valid;
    flags[FLAG_GYRO_VALID] = gyro_valid;
    return {HEADER_BYTE, roll, pitch, yaw,
            gyro_x, gyro_y, gyro_z,
            flags, 16'h0000};
  endfunction

endpackage

// File: rtl/sensor_packet_spi_master_sck_gen.sv
// spi_sck_phase_gen: CPOL=0 sck generator, CLK_DIV clk
// cycles per half-period, idles low while disabled.
module spi_sck_phase_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck_level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;
  logic          half_end;

  assign half_end   = en && (cnt == LAST);
  assign rise_pulse = half_end && !sck_level;
  assign fall_pulse = half_end && sck_level;

  // half-period counter; level toggles at each terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sck_level <= 1'b0;
    end else if (!en) begin
      cnt       <= '0;
      sck_level <= 1'b0;
    end else if (half_end) begin
      cnt       <= '0;
      sck_level <= ~sck_level;
    end else begin
      cnt       <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_packet_spi_master.sv
// sensor_packet_spi_master: SPI mode 0 master that latches
// a 16-byte sensor packet on start and shifts it MSB-first.
module sensor_packet_spi_master
  import sensor_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] roll,
  input  logic [15:0] pitch,
  input  logic [15:0] yaw,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  input  logic        quat_valid,
  input  logic        gyro_valid,
  output logic        cs_n,
  output logic        sck,
  output logic        sdo,
  output logic        busy,
  output logic        done
);

  localparam int CM1 =
    (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CMAX = (CM1 > CS_GAP) ? CM1 : CS_GAP;
  localparam int CW =
    (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

  spi_state_e state, state_d;

  logic [CW-1:0]          cnt, cnt_d;
  logic [6:0]             bit_idx, bit_d;
  logic                   last_bit, last_d;
  logic [PACKET_BITS-1:0] shreg, shreg_d;
  logic [PACKET_BITS-1:0] pkt;
  logic                   cs_n_d, sdo_d, busy_d, done_d;
  logic                   shift_en, rise_pulse, fall_pulse;

  assign pkt = build_packet(roll, pitch, yaw,
                            gyro_x, gyro_y, gyro_z,
                            quat_valid, gyro_valid);

  assign shift_en = (state == ST_SHIFT);

  spi_sck_phase_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (shift_en),
    .sck_level (sck),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  // state, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      last_bit <= 1'b0;
      shreg    <= '0;
      cs_n     <= 1'b1;
      sdo      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      last_bit <= last_d;
      shreg    <= shreg_d;
      cs_n     <= cs_n_d;
      sdo      <= sdo_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // next-state and next-output decode for the frame sequence
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    last_d  = last_bit;
    shreg_d = shreg;
    cs_n_d  = cs_n;
    sdo_d   = sdo;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          shreg_d = {pkt[PACKET_BITS-2:0], 1'b0};
          sdo_d   = pkt[PACKET_BITS-1];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          last_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_SHIFT: begin
        // the final-bit decision is taken at the sample edge
        if (rise_pulse) begin
          last_d = (bit_idx == 7'd127);
        end
        if (fall_pulse) begin
          if (last_bit) begin
            sdo_d   = 1'b0;
            state_d = ST_HOLD;
          end else begin
            sdo_d   = shreg[PACKET_BITS-1];
            shreg_d = {shreg[PACKET_BITS-2:0], 1'b0};
            bit_d   = bit_idx + 7'd1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
